// File: rtl/mac_datapath.sv
// mac_datapath
// Arithmetic stage of the MAC unit, fed by the control FSM's 2-bit op code.
// Two-stage pipeline: stage 1 registers the unsigned product A*B and the op
// code; stage 2 applies the registered op to the accumulator, overflow flag
// and term counter, and on DUMP publishes them on the registered result port.
//
// Ports:
//   CLK        in   1       rising-edge clock
//   RST        in   1       asynchronous active-high reset
//   CTRL       in   2       op code: 00 NOP, 01 MAC, 10 LOAD, 11 DUMP
//   A, B       in   DATA_W  unsigned operands, sampled with CTRL
//   ACC_OUT    out  ACC_W   accumulator value captured by the last DUMP
//   OUT_VALID  out  1       one-cycle strobe for a new ACC_OUT
//   OVF_OUT    out  1       sticky overflow of the dumped sum
//   TERMS      out  CNT_W   saturating number of products in the dumped sum
module mac_datapath #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        CTRL,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [ACC_W-1:0]  ACC_OUT,
  output logic              OUT_VALID,
  output logic              OVF_OUT,
  output logic [CNT_W-1:0]  TERMS
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_MAC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_DUMP = 2'b11
  } op_t;

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] p_reg_r;
  op_t               op_reg_r;
  logic [ACC_W-1:0]  acc_r;
  logic              ovf_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [ACC_W:0]    sum_s;     // one extra bit holds the carry out
  logic [ACC_W-1:0]  acc_nxt_s;
  logic              ovf_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              dump_s;

  // Stage 1: register the product and the op code every cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_reg_r  <= {PROD_W{1'b0}};
      op_reg_r <= OP_NOP;
    end else begin
      p_reg_r  <= A * B;
      op_reg_r <= op_t'(CTRL);
    end
  end

  // Stage 2 next-state: decode the registered op against the accumulator state.
  always_comb begin
    sum_s     = {1'b0, acc_r} + (ACC_W+1)'(p_reg_r);
    acc_nxt_s = acc_r;
    ovf_nxt_s = ovf_r;
    cnt_nxt_s = cnt_r;
    dump_s    = 1'b0;
    case (op_reg_r)
      OP_NOP: begin
        acc_nxt_s = acc_r;
      end
      OP_MAC: begin
        acc_nxt_s = sum_s[ACC_W-1:0];
        ovf_nxt_s = ovf_r | sum_s[ACC_W];
        if (cnt_r == {CNT_W{1'b1}}) begin
          cnt_nxt_s = cnt_r;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      OP_LOAD: begin
        acc_nxt_s = ACC_W'(p_reg_r);
        ovf_nxt_s = 1'b0;
        cnt_nxt_s = CNT_W'(1);
      end
      OP_DUMP: begin
        // The product registered alongside DUMP is dropped.
        acc_nxt_s = {ACC_W{1'b0}};
        ovf_nxt_s = 1'b0;
        cnt_nxt_s = {CNT_W{1'b0}};
        dump_s    = 1'b1;
      end
      default: begin
        acc_nxt_s = acc_r;
      end
    endcase
  end

  // Stage 2 state: accumulator, sticky overflow and term counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      acc_r <= acc_nxt_s;
      ovf_r <= ovf_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  // Result port: capture the sum on DUMP and strobe valid for that cycle only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ACC_OUT   <= {ACC_W{1'b0}};
      OUT_VALID <= 1'b0;
      OVF_OUT   <= 1'b0;
      TERMS     <= {CNT_W{1'b0}};
    end else if (dump_s) begin
      ACC_OUT   <= acc_r;
      OUT_VALID <= 1'b1;
      OVF_OUT   <= ovf_r;
      TERMS     <= cnt_r;
    end else begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_datapath.sv
// Directed bench for mac_datapath. A default-parameter instance carries most
// checks; a CNT_W=4 instance on the same inputs covers term-counter saturation.
module tb_mac_datapath;

  logic        CLK;
  logic        RST;
  logic [1:0]  CTRL;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [19:0] ACC_OUT;
  logic        OUT_VALID;
  logic        OVF_OUT;
  logic [7:0]  TERMS;
  logic [19:0] s_acc_out;
  logic        s_out_valid;
  logic        s_ovf_out;
  logic [3:0]  s_terms;

  int total;
  int bad;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] MAC  = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] DUMP = 2'b11;

  mac_datapath dut (
    .CLK(CLK), .RST(RST), .CTRL(CTRL), .A(A), .B(B),
    .ACC_OUT(ACC_OUT), .OUT_VALID(OUT_VALID), .OVF_OUT(OVF_OUT), .TERMS(TERMS)
  );

  mac_datapath #(.DATA_W(8), .ACC_W(20), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(RST), .CTRL(CTRL), .A(A), .B(B),
    .ACC_OUT(s_acc_out), .OUT_VALID(s_out_valid), .OVF_OUT(s_ovf_out), .TERMS(s_terms)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one op, then return 1 time unit after the edge that samples it.
  task automatic op(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
    CTRL = c;
    A    = a;
    B    = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b1;
    CTRL  = NOP;
    A     = 8'd0;
    B     = 8'd0;
    #12;
    check("rst_acc", 32'(ACC_OUT), 32'd0);
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_ovf", 32'(OVF_OUT), 32'd0);
    check("rst_terms", 32'(TERMS), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Basic sum: 12 + 30 + 65025
    op(LOAD, 8'd3, 8'd4);
    op(MAC, 8'd5, 8'd6);
    op(MAC, 8'd255, 8'd255);
    op(DUMP, 8'd0, 8'd0);
    check("basic_valid_early", 32'(OUT_VALID), 32'd0);
    op(NOP, 8'd0, 8'd0);
    check("basic_acc", 32'(ACC_OUT), 32'd65067);
    check("basic_terms", 32'(TERMS), 32'd3);
    check("basic_ovf", 32'(OVF_OUT), 32'd0);
    check("basic_valid", 32'(OUT_VALID), 32'd1);
    op(NOP, 8'd0, 8'd0);
    check("basic_valid_drop", 32'(OUT_VALID), 32'd0);
    check("basic_acc_hold", 32'(ACC_OUT), 32'd65067);

    // Reset while a DUMP sits in op_reg
    op(LOAD, 8'd2, 8'd2);
    op(DUMP, 8'd0, 8'd0);
    RST = 1'b1;
    #1;
    check("mrst_acc", 32'(ACC_OUT), 32'd0);
    check("mrst_valid", 32'(OUT_VALID), 32'd0);
    check("mrst_terms", 32'(TERMS), 32'd0);
    check("mrst_ovf", 32'(OVF_OUT), 32'd0);
    CTRL = NOP;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    op(NOP, 8'd0, 8'd0);
    check("mrst_no_strobe1", 32'(OUT_VALID), 32'd0);
    op(NOP, 8'd0, 8'd0);
    check("mrst_no_strobe2", 32'(OUT_VALID), 32'd0);
    op(DUMP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);
    check("mrst_dump_valid", 32'(OUT_VALID), 32'd1);
    check("mrst_dump_acc", 32'(ACC_OUT), 32'd0);
    check("mrst_dump_terms", 32'(TERMS), 32'd0);

    // Overflow: 17 * 65025 = 1105425 -> mod 2^20 = 56849
    op(LOAD, 8'd255, 8'd255);
    for (int i = 0; i < 16; i++) op(MAC, 8'd255, 8'd255);
    op(DUMP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);
    check("ovf_acc", 32'(ACC_OUT), 32'd56849);
    check("ovf_flag", 32'(OVF_OUT), 32'd1);
    check("ovf_terms", 32'(TERMS), 32'd17);
    check("ovf_valid", 32'(OUT_VALID), 32'd1);
    op(LOAD, 8'd1, 8'd1);
    op(DUMP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);
    check("ovf_clr_acc", 32'(ACC_OUT), 32'd1);
    check("ovf_clr_flag", 32'(OVF_OUT), 32'd0);
    check("ovf_clr_terms", 32'(TERMS), 32'd1);

    // Back-to-back dumps
    op(LOAD, 8'd7, 8'd1);
    op(DUMP, 8'd9, 8'd9);
    op(DUMP, 8'd9, 8'd9);
    check("b2b_1_valid", 32'(OUT_VALID), 32'd1);
    check("b2b_1_acc", 32'(ACC_OUT), 32'd7);
    check("b2b_1_terms", 32'(TERMS), 32'd1);
    op(MAC, 8'd2, 8'd3);
    check("b2b_2_valid", 32'(OUT_VALID), 32'd1);
    check("b2b_2_acc", 32'(ACC_OUT), 32'd0);
    check("b2b_2_terms", 32'(TERMS), 32'd0);
    check("b2b_2_ovf", 32'(OVF_OUT), 32'd0);
    op(DUMP, 8'd0, 8'd0);
    check("b2b_gap_valid", 32'(OUT_VALID), 32'd0);
    op(NOP, 8'd0, 8'd0);
    check("b2b_3_valid", 32'(OUT_VALID), 32'd1);
    check("b2b_3_acc", 32'(ACC_OUT), 32'd6);
    check("b2b_3_terms", 32'(TERMS), 32'd1);
    op(NOP, 8'd0, 8'd0);
    check("b2b_end_valid", 32'(OUT_VALID), 32'd0);

    // NOP hold with random operands
    op(LOAD, 8'd10, 8'd10);
    for (int i = 0; i < 5; i++) op(NOP, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    op(DUMP, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    op(NOP, 8'd0, 8'd0);
    check("nop_acc", 32'(ACC_OUT), 32'd100);
    check("nop_terms", 32'(TERMS), 32'd1);
    check("nop_valid", 32'(OUT_VALID), 32'd1);

    // Counter saturation: 21 products of 1
    op(LOAD, 8'd1, 8'd1);
    for (int i = 0; i < 20; i++) op(MAC, 8'd1, 8'd1);
    op(DUMP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);
    check("sat_acc", 32'(s_acc_out), 32'd21);
    check("sat_terms", 32'(s_terms), 32'd15);
    check("sat_ovf", 32'(s_ovf_out), 32'd0);
    check("sat_valid", 32'(s_out_valid), 32'd1);
    check("wide_terms", 32'(TERMS), 32'd21);
    check("wide_acc", 32'(ACC_OUT), 32'd21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_datapath.md
# mac_datapath

Arithmetic stage of the MAC unit, directly downstream of the 3-state control FSM. It consumes the FSM's 2-bit output code each cycle and executes one operation on two operand buses: no-op, multiply-accumulate, load, or dump. The stage is a two-stage pipeline (registered product, then accumulator) with a registered result port, a one-cycle valid strobe, sticky overflow, and a term counter.

## Interface
Parameters:
- DATA_W, 8: operand width; operands are unsigned.
- ACC_W, 20: accumulator and result width; must be ≥ 2*DATA_W.
- CNT_W, 8: term-counter width.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- CTRL  in  2  operation code from the FSM output: 00 NOP, 01 MAC, 10 LOAD, 11 DUMP.
- A  in  DATA_W  operand A, sampled together with CTRL.
- B  in  DATA_W  operand B, sampled together with CTRL.
- ACC_OUT  out  ACC_W  dumped accumulator value; holds until the next DUMP.
- OUT_VALID  out  1  one-cycle strobe marking a new ACC_OUT.
- OVF_OUT  out  1  overflow status of the dumped sum.
- TERMS  out  CNT_W  number of products in the dumped sum, saturating.

## Operation
Stage 1, every edge:
- p_reg <= A*B (2*DATA_W bits, unsigned).
- op_reg <= CTRL.

Stage 2, every edge, acts on op_reg:
- NOP (00): acc, ovf and cnt hold.
- MAC (01): acc <= acc + zero-extended p_reg, computed mod 2^ACC_W. A carry out of bit ACC_W-1 sets ovf; ovf is sticky. cnt <= cnt+1, saturating at all-ones.
- LOAD (10): acc <= p_reg, ovf <= 0, cnt <= 1. This starts a new sum.
- DUMP (11):
  - ACC_OUT <= acc, OVF_OUT <= ovf, TERMS <= cnt, OUT_VALID <= 1.
  - acc, ovf and cnt are cleared to 0.
  - The product in p_reg is discarded.

OUT_VALID:
- Equals 0 on every edge where op_reg ≠ 11.
- Back-to-back DUMPs give back-to-back strobes; the second one reports 0 / 0 / 0.

Internal state (acc, ovf, cnt) is not visible until a DUMP occurs.

## Timing
- Reset values: p_reg=0, op_reg=00, acc=0, ovf=0, cnt=0, ACC_OUT=0, OUT_VALID=0, OVF_OUT=0, TERMS=0.
- Because op_reg resets to 00, the first edge after reset release executes a NOP.
- Latency: CTRL/A/B sampled at edge k take effect on acc at edge k+1. A DUMP sampled at edge k shows ACC_OUT/OUT_VALID after edge k+1. DUMP-to-strobe latency is therefore 2 edges from the CTRL change.
- Throughput: one operation per cycle, no stalls, no handshake. The FSM is not back-pressured.
- Sequence rules:
  - MAC at k+1 following DUMP at k adds onto the cleared accumulator.
  - LOAD following MAC discards the prior sum and its ovf.
  - A MAC-only sequence after reset or DUMP starts from 0.
- Wrap-around:
  - Products never overflow 2*DATA_W bits.
  - On accumulator wrap, acc keeps the low ACC_W bits and ovf=1 until the next LOAD or DUMP.
- Counter saturation: cnt stays at 2^CNT_W-1 once reached; ovf is not affected.
- Reset mid-operation: everything asserted as above takes effect immediately, including a pending DUMP in op_reg. No OUT_VALID is emitted for it.
- Operands are don't-care for NOP and DUMP but are still registered.

## Test plan
- Reset: assert RST mid-stream with op_reg=11 → all outputs 0 immediately; no OUT_VALID strobe after release; first post-reset DUMP gives ACC_OUT=0, TERMS=0.
- Basic sum:
  - Stimulus: LOAD(3,4), MAC(5,6), MAC(255,255), DUMP on consecutive cycles.
  - Response: one cycle after DUMP is sampled, ACC_OUT=12+30+65025=65067, TERMS=3, OVF_OUT=0, OUT_VALID high exactly one cycle.
- Overflow (ACC_W=20):
  - Stimulus: LOAD(255,255) followed by 16 MAC(255,255) (17 products of 65025), then DUMP.
  - Response: ACC_OUT=(17*65025) mod 2^20 = 56849, OVF_OUT=1, TERMS=17. A following LOAD(1,1), DUMP gives ACC_OUT=1, OVF_OUT=0.
- Back-to-back dumps: DUMP, DUMP, MAC(2,3), DUMP → strobes on three cycles with ACC_OUT values prior-sum, 0, 6 and TERMS values prior, 0, 1.
- NOP hold: LOAD(10,10), 5 NOPs with random A/B, DUMP → ACC_OUT=100, TERMS=1.
- Counter saturation (CNT_W=4): LOAD(1,1) + 20 MAC(1,1), DUMP → ACC_OUT=21, TERMS=15, OVF_OUT=0.
